// File: rtl/hive_stack_mem.sv
// rtl/hive_stack_mem.sv - per-thread BRAM LIFO storage, stage 6 address/write to stage 0 data
//
// Purpose: stack memory indexed by {thread, level}. Writes push data_6_i at the
// addressed slot; every cycle the same slot is read as top-of-stack and returned
// two clocks later (stage 6 -> 7 -> 0). Read-during-write is write-first.
//
// Ports:
//   clk_i       clock
//   rst_i       async reset, active high (clears stage-7 and stage-0 pipe registers)
//   thrd_6_i    thread ID at stage 6
//   level_6_i   stack level at stage 6 (level 0 = empty)
//   wr_6_i      write enable at stage 6
//   data_6_i    push data at stage 6
//   data_0_o    top-of-stack data at stage 0 (0 when empty)
//   empty_0_o   stack was empty at the stage-6 read
//   par_er_0_o  parity error at stage 0
//
// Optional feature: define HIVE_STK_PARITY_EN to store an even-parity bit per
// word and flag mismatches on par_er_0_o. Undefined, par_er_0_o is tied 0.

module hive_stack_mem #(
    parameter int THRD_W    = 3,
    parameter int STK_LVL_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [THRD_W-1:0]    thrd_6_i,
    input  logic [STK_LVL_W-1:0] level_6_i,
    input  logic                 wr_6_i,
    input  logic [DATA_W-1:0]    data_6_i,
    output logic [DATA_W-1:0]    data_0_o,
    output logic                 empty_0_o,
    output logic                 par_er_0_o
);

    localparam int ADDR_W = THRD_W + STK_LVL_W - 1;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef HIVE_STK_PARITY_EN
    localparam int MEM_W  = DATA_W + 1;
`else
    localparam int MEM_W  = DATA_W;
`endif

    // Dropping the level MSB makes the full level (2^(STK_LVL_W-1)) wrap to slot 0;
    // level 0 also maps there but is flagged empty and never returned.
    logic [ADDR_W-1:0] w_addr;
    logic [MEM_W-1:0]  w_wr_word;
    logic              w_empty_6;

    assign w_addr    = {thrd_6_i, level_6_i[STK_LVL_W-2:0]};
    assign w_empty_6 = (level_6_i == '0);
`ifdef HIVE_STK_PARITY_EN
    assign w_wr_word = {^data_6_i, data_6_i};
`else
    assign w_wr_word = data_6_i;
`endif

    // Memory array and its read register carry no reset so they map onto block RAM.
    // The read is read-first; write-first behaviour comes from the bypass below.
    logic [MEM_W-1:0] r_mem [0:DEPTH-1];
    logic [MEM_W-1:0] r_rd_7;

    always_ff @(posedge clk_i) begin
        if (wr_6_i) begin
            r_mem[w_addr] <= w_wr_word;
        end
        r_rd_7 <= r_mem[w_addr];
    end

    // Stage 7 control: empty flag and write-first bypass. Read and write always
    // share one address, so any write this cycle is a same-address bypass.
    logic              r_empty_7;
    logic              r_byp_7;
    logic [DATA_W-1:0] r_byp_data_7;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_empty_7    <= 1'b1;
            r_byp_7      <= 1'b0;
            r_byp_data_7 <= '0;
        end else begin
            r_empty_7    <= w_empty_6;
            r_byp_7      <= wr_6_i;
            r_byp_data_7 <= data_6_i;
        end
    end

    // Stage 0 output register: empty dominates, then bypass, then memory data.
    logic [DATA_W-1:0] r_data_0;
    logic              r_empty_0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data_0  <= '0;
            r_empty_0 <= 1'b1;
        end else begin
            r_empty_0 <= r_empty_7;
            if (r_empty_7) begin
                r_data_0 <= '0;
            end else if (r_byp_7) begin
                r_data_0 <= r_byp_data_7;
            end else begin
                r_data_0 <= r_rd_7[DATA_W-1:0];
            end
        end
    end

    assign data_0_o  = r_data_0;
    assign empty_0_o = r_empty_0;

`ifdef HIVE_STK_PARITY_EN
    // Stored word including its parity bit must XOR to 0; only the memory path is checked.
    logic r_par_er_0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_par_er_0 <= 1'b0;
        end else begin
            r_par_er_0 <= !r_empty_7 && !r_byp_7 && (^r_rd_7);
        end
    end

    assign par_er_0_o = r_par_er_0;
`else
    assign par_er_0_o = 1'b0;
`endif

endmodule

// File: tb/tb_hive_stack_mem.sv
// tb/tb_hive_stack_mem.sv - scoreboard bench for hive_stack_mem with a behavioural stack model

module tb_hive_stack_mem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  thrd_6_i;
    logic [4:0]  level_6_i;
    logic        wr_6_i;
    logic [31:0] data_6_i;
    logic [31:0] data_0_o;
    logic        empty_0_o;
    logic        par_er_0_o;

    hive_stack_mem dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .thrd_6_i   (thrd_6_i),
        .level_6_i  (level_6_i),
        .wr_6_i     (wr_6_i),
        .data_6_i   (data_6_i),
        .data_0_o   (data_0_o),
        .empty_0_o  (empty_0_o),
        .par_er_0_o (par_er_0_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned cyc;
        logic [31:0] d;
        logic        e;
        logic        chk_d;
        logic        par;
    } exp_t;

    exp_t        q[$];
    int unsigned edge_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    // Reference model: one word per (thread, level mod 16) slot.
    logic [31:0] m_data [0:127];
    bit          m_valid[0:127];
    bit          m_bad  [0:127];

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies inputs for one stage-6 cycle (called #1 after a posedge) and queues the expectation.
    task automatic step(input int t, input int lvl, input bit wr, input logic [31:0] d);
        exp_t x;
        int   a;
        thrd_6_i  = t[2:0];
        level_6_i = lvl[4:0];
        wr_6_i    = wr;
        data_6_i  = d;
        a         = t * 16 + (lvl % 16);
        x.cyc     = edge_cnt + 1;
        x.par     = 1'b0;
        if (lvl == 0) begin
            x.d = 32'h0; x.e = 1'b1; x.chk_d = 1'b1;
        end else if (wr) begin
            x.d = d; x.e = 1'b0; x.chk_d = 1'b1;
        end else begin
            x.d = m_data[a]; x.e = 1'b0; x.chk_d = m_valid[a];
            x.par = m_bad[a];
        end
        q.push_back(x);
        if (wr) begin
            m_data[a] = d; m_valid[a] = 1'b1; m_bad[a] = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: the DUT presents an output every cycle; compare it with the entry issued two edges earlier.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            while (q.size() > 0 && q[0].cyc + 1 <= edge_cnt) begin
                exp_t x;
                x = q.pop_front();
                if (x.cyc + 1 != edge_cnt) begin
                    n_chk++; n_err++;
                    $display("FAIL missed_output: issued edge %0d, now edge %0d", x.cyc, edge_cnt);
                end else begin
                    chk("empty", {31'b0, empty_0_o}, {31'b0, x.e});
                    if (x.chk_d) chk("data", data_0_o, x.d);
                    chk("par_er", {31'b0, par_er_0_o}, {31'b0, x.par});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            m_valid[i] = 1'b0; m_bad[i] = 1'b0; m_data[i] = 32'h0;
        end
        rst_i = 1'b1; thrd_6_i = '0; level_6_i = '0; wr_6_i = 1'b0; data_6_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_data", data_0_o, 32'h0);
        chk("rst_empty", {31'b0, empty_0_o}, 32'h1);
        chk("rst_par", {31'b0, par_er_0_o}, 32'h0);
        rst_i = 1'b0;

        // Push at thread 3 level 1, then re-read 8 cycles later.
        step(3, 1, 1'b1, 32'hDEADBEEF);
        for (int t = 4; t < 11; t++) step(t % 8, 0, 1'b0, 32'h0);
        step(3, 1, 1'b0, 32'h0);

        // Per-thread isolation.
        for (int t = 0; t < 8; t++) step(t, 1, 1'b1, 32'h1000 + t);
        for (int t = 0; t < 8; t++) step(t, 1, 1'b0, 32'h0);

        // Depth and wrap on thread 0.
        for (int l = 1; l <= 16; l++) step(0, l, 1'b1, l);
        step(0, 16, 1'b0, 32'h0);
        step(0, 15, 1'b0, 32'h0);
        step(0, 1, 1'b0, 32'h0);

        // Empty then non-empty.
        step(0, 0, 1'b0, 32'h0);
        step(0, 1, 1'b0, 32'h0);

`ifdef HIVE_STK_PARITY_EN
        step(2, 4, 1'b1, 32'hA5A5_0F0F);
        dut.r_mem[2 * 16 + 4][0] = ~dut.r_mem[2 * 16 + 4][0];
        m_data[2 * 16 + 4][0] = ~m_data[2 * 16 + 4][0];
        m_bad[2 * 16 + 4] = 1'b1;
        step(2, 4, 1'b0, 32'h0);
        step(3, 1, 1'b0, 32'h0);
        step(2, 4, 1'b1, 32'h0000_0042);
        step(2, 4, 1'b0, 32'h0);
`endif

        // Randomized traffic, including push-error levels above 16.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7), $urandom_range(0, 20), 1'($urandom_range(0, 1)), $urandom);
        end

        // Mid-stream reset: outputs clear immediately and stay clear.
        rst_i = 1'b1;
        wr_6_i = 1'b0;
        #1;
        chk("mid_rst_data", data_0_o, 32'h0);
        chk("mid_rst_empty", {31'b0, empty_0_o}, 32'h1);
        chk("mid_rst_par", {31'b0, par_er_0_o}, 32'h0);
        q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        chk("hold_rst_data", data_0_o, 32'h0);
        chk("hold_rst_empty", {31'b0, empty_0_o}, 32'h1);
        rst_i = 1'b0;

        // Valid output resumes 2 cycles after deassert; memory contents survive reset.
        for (int t = 0; t < 8; t++) step(t, $urandom_range(1, 16), 1'b0, 32'h0);
        step(5, 7, 1'b1, 32'h1234_5678);
        step(5, 7, 1'b0, 32'h0);
        step(5, 0, 1'b0, 32'h0);

        repeat (3) @(posedge clk_i);
        #1;
        chk("queue_drained", q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
